// File: rtl/debounce_fsm_bank.sv
// ============================================================================
// Module   : debounce_fsm_bank
// Brief    : Bank of independent per-channel debounce FSMs with polarity
//            chosen at elaboration time; commits after HOLD enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_fsm_bank #(
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int HOLD     = 3,
    parameter int CW       = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] b,
    output logic [CHANNELS-1:0] chg,
    output logic [CHANNELS-1:0] glitch,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1
    } state_t;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] c_CNT_ZERO = '0;

    logic [CHANNELS-1:0] w_qual_nxt;
    logic                r_busy;

    generate
        if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
            $error("debounce_fsm_bank: CHANNELS must be 1..32");
        end
        if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
            $error("debounce_fsm_bank: HOLD must be 1..15");
        end
        if (HOLD > (2 ** CW) - 1) begin : g_bad_cw
            $error("debounce_fsm_bank: CW too narrow for HOLD");
        end
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("debounce_fsm_bank: MODE must be 0 or 1");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_chan
            if (MODE == 0) begin : g_noninv
                state_t        r_state, w_state_nxt;
                logic [CW-1:0] r_cnt, w_cnt_nxt;
                logic          r_b, w_b_nxt;
                logic          r_chg, w_chg_nxt;
                logic          r_glitch, w_glitch_nxt;
                logic          w_a_eff;
                logic          w_mis;

                assign w_a_eff = a[i];
                assign w_mis   = (w_a_eff != r_b);

                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= c_CNT_ZERO;
                        r_b      <= 1'b0;
                        r_chg    <= 1'b0;
                        r_glitch <= 1'b0;
                    end else begin
                        r_state  <= w_state_nxt;
                        r_cnt    <= w_cnt_nxt;
                        r_b      <= w_b_nxt;
                        r_chg    <= w_chg_nxt;
                        r_glitch <= w_glitch_nxt;
                    end
                end

                always_comb begin
                    w_state_nxt  = r_state;
                    w_cnt_nxt    = r_cnt;
                    w_b_nxt      = r_b;
                    w_chg_nxt    = 1'b0;
                    w_glitch_nxt = 1'b0;
                    if (en) begin
                        case (r_state)
                            ST_IDLE: begin
                                if (w_mis) begin
                                    if (HOLD == 1) begin
                                        w_b_nxt   = w_a_eff;
                                        w_chg_nxt = 1'b1;
                                    end else begin
                                        w_state_nxt = ST_QUAL;
                                        w_cnt_nxt   = c_CNT_ONE;
                                    end
                                end
                            end
                            ST_QUAL: begin
                                if (!w_mis) begin
                                    w_state_nxt  = ST_IDLE;
                                    w_cnt_nxt    = c_CNT_ZERO;
                                    w_glitch_nxt = 1'b1;
                                end else if (r_cnt == c_CNT_LAST) begin
                                    w_b_nxt     = w_a_eff;
                                    w_chg_nxt   = 1'b1;
                                    w_state_nxt = ST_IDLE;
                                    w_cnt_nxt   = c_CNT_ZERO;
                                end else begin
                                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                                end
                            end
                            default: begin
                                w_state_nxt = ST_IDLE;
                                w_cnt_nxt   = c_CNT_ZERO;
                            end
                        endcase
                    end
                end

                assign b[i]          = r_b;
                assign chg[i]        = r_chg;
                assign glitch[i]     = r_glitch;
                assign w_qual_nxt[i] = (w_state_nxt == ST_QUAL);
            end else begin : g_inv
                // Same machine, qualifying the complemented input.
                state_t        r_state, w_state_nxt;
                logic [CW-1:0] r_cnt, w_cnt_nxt;
                logic          r_b, w_b_nxt;
                logic          r_chg, w_chg_nxt;
                logic          r_glitch, w_glitch_nxt;
                logic          w_a_eff;
                logic          w_mis;

                assign w_a_eff = ~a[i];
                assign w_mis   = (w_a_eff != r_b);

                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= c_CNT_ZERO;
                        r_b      <= 1'b0;
                        r_chg    <= 1'b0;
                        r_glitch <= 1'b0;
                    end else begin
                        r_state  <= w_state_nxt;
                        r_cnt    <= w_cnt_nxt;
                        r_b      <= w_b_nxt;
                        r_chg    <= w_chg_nxt;
                        r_glitch <= w_glitch_nxt;
                    end
                end

                always_comb begin
                    w_state_nxt  = r_state;
                    w_cnt_nxt    = r_cnt;
                    w_b_nxt      = r_b;
                    w_chg_nxt    = 1'b0;
                    w_glitch_nxt = 1'b0;
                    if (en) begin
                        case (r_state)
                            ST_IDLE: begin
                                if (w_mis) begin
                                    if (HOLD == 1) begin
                                        w_b_nxt   = w_a_eff;
                                        w_chg_nxt = 1'b1;
                                    end else begin
                                        w_state_nxt = ST_QUAL;
                                        w_cnt_nxt   = c_CNT_ONE;
                                    end
                                end
                            end
                            ST_QUAL: begin
                                if (!w_mis) begin
                                    w_state_nxt  = ST_IDLE;
                                    w_cnt_nxt    = c_CNT_ZERO;
                                    w_glitch_nxt = 1'b1;
                                end else if (r_cnt == c_CNT_LAST) begin
                                    w_b_nxt     = w_a_eff;
                                    w_chg_nxt   = 1'b1;
                                    w_state_nxt = ST_IDLE;
                                    w_cnt_nxt   = c_CNT_ZERO;
                                end else begin
                                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                                end
                            end
                            default: begin
                                w_state_nxt = ST_IDLE;
                                w_cnt_nxt   = c_CNT_ZERO;
                            end
                        endcase
                    end
                end

                assign b[i]          = r_b;
                assign chg[i]        = r_chg;
                assign glitch[i]     = r_glitch;
                assign w_qual_nxt[i] = (w_state_nxt == ST_QUAL);
            end
        end
    endgenerate

    // Registered from next-state so it rises with the edge that enters QUAL.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_qual_nxt;
        end
    end

    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_debounce_fsm_bank.sv
// ============================================================================
// Module   : tb_debounce_fsm_bank
// Brief    : Self-checking bench for three debounce_fsm_bank variants driven
//            by shared directed stimulus, checked against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_fsm_bank;

    logic       clock;
    logic       reset;
    logic       en;
    logic [3:0] a;

    logic [3:0] b_o      [3];
    logic [3:0] chg_o    [3];
    logic [3:0] glitch_o [3];
    logic       busy_o   [3];

    // Instance 0: non-inverting, HOLD 3; 1: inverting, HOLD 3; 2: non-inverting, HOLD 1
    debounce_fsm_bank #(.CHANNELS(4), .MODE(0), .HOLD(3), .CW(4)) u_dut0 (
        .clock(clock), .reset(reset), .en(en), .a(a),
        .b(b_o[0]), .chg(chg_o[0]), .glitch(glitch_o[0]), .busy(busy_o[0]));
    debounce_fsm_bank #(.CHANNELS(4), .MODE(1), .HOLD(3), .CW(4)) u_dut1 (
        .clock(clock), .reset(reset), .en(en), .a(a),
        .b(b_o[1]), .chg(chg_o[1]), .glitch(glitch_o[1]), .busy(busy_o[1]));
    debounce_fsm_bank #(.CHANNELS(4), .MODE(0), .HOLD(1), .CW(4)) u_dut2 (
        .clock(clock), .reset(reset), .en(en), .a(a),
        .b(b_o[2]), .chg(chg_o[2]), .glitch(glitch_o[2]), .busy(busy_o[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: b commits once a_eff has differed from b for HOLD enabled cycles in a row.
    int         hold_of [3] = '{3, 3, 1};
    logic       inv_of  [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] m_b      [3];
    logic [3:0] m_chg    [3];
    logic [3:0] m_glitch [3];
    int         m_run    [3][4];
    bit         armed = 0;

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                logic eff;
                if (reset) begin
                    m_b[k][c]      = 1'b0;
                    m_chg[k][c]    = 1'b0;
                    m_glitch[k][c] = 1'b0;
                    m_run[k][c]    = 0;
                end else begin
                    m_chg[k][c]    = 1'b0;
                    m_glitch[k][c] = 1'b0;
                    if (en) begin
                        eff = a[c] ^ inv_of[k];
                        if (eff != m_b[k][c]) begin
                            m_run[k][c] = m_run[k][c] + 1;
                            if (m_run[k][c] == hold_of[k]) begin
                                m_b[k][c]   = eff;
                                m_chg[k][c] = 1'b1;
                                m_run[k][c] = 0;
                            end
                        end else begin
                            if (m_run[k][c] != 0) m_glitch[k][c] = 1'b1;
                            m_run[k][c] = 0;
                        end
                    end
                end
            end
        end
        if (reset) armed = 1;
    end

    always @(negedge clock) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                logic m_busy;
                m_busy = 1'b0;
                for (int c = 0; c < 4; c++) if (m_run[k][c] != 0) m_busy = 1'b1;
                check($sformatf("model_b[%0d]", k),      32'(b_o[k]),      32'(m_b[k]));
                check($sformatf("model_chg[%0d]", k),    32'(chg_o[k]),    32'(m_chg[k]));
                check($sformatf("model_glitch[%0d]", k), 32'(glitch_o[k]), 32'(m_glitch[k]));
                check($sformatf("model_busy[%0d]", k),   32'(busy_o[k]),   32'(m_busy));
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [3:0] av);
        @(negedge clock);
        reset = r;
        en    = e;
        a     = av;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        a     = 4'b0000;

        // Reset state
        step(1, 1, 4'b0000);
        step(1, 1, 4'b0000);
        check("rst_b0", 32'(b_o[0]), 32'h0);
        check("rst_b1", 32'(b_o[1]), 32'h0);
        check("rst_busy0", 32'(busy_o[0]), 32'h0);
        check("rst_chg1", 32'(chg_o[1]), 32'h0);

        // Basic commit on channel 0 after 3 edges; inverting bank commits 1110 then
        step(0, 1, 4'b0001);
        check("t1_busy_e1", 32'(busy_o[0]), 32'h1);
        check("t1_h1_b", 32'(b_o[2]), 32'h1);
        check("t1_h1_chg", 32'(chg_o[2]), 32'h1);
        step(0, 1, 4'b0001);
        check("t1_b_e2", 32'(b_o[0]), 32'h0);
        step(0, 1, 4'b0001);
        check("t1_b_e3", 32'(b_o[0]), 32'h1);
        check("t1_chg_e3", 32'(chg_o[0]), 32'h1);
        check("t1_busy_e3", 32'(busy_o[0]), 32'h0);
        check("t1_inv_b", 32'(b_o[1]), 32'he);
        step(0, 1, 4'b0001);
        check("t1_chg_e4", 32'(chg_o[0]), 32'h0);

        // Inverting bank with a held low
        step(1, 1, 4'b0000);
        step(0, 1, 4'b0000);
        step(0, 1, 4'b0000);
        check("t3_inv_b_e2", 32'(b_o[1]), 32'h0);
        step(0, 1, 4'b0000);
        check("t3_inv_b_e3", 32'(b_o[1]), 32'hf);
        check("t3_inv_chg", 32'(chg_o[1]), 32'hf);

        // Glitch on channel 1
        step(1, 1, 4'b0000);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0000);
        check("t2_glitch", 32'(glitch_o[0]), 32'h2);
        check("t2_b", 32'(b_o[0]), 32'h0);
        check("t2_chg", 32'(chg_o[0]), 32'h0);
        step(0, 1, 4'b0000);
        check("t2_glitch_clr", 32'(glitch_o[0]), 32'h0);

        // Enable gaps do not count and do not break qualification
        step(1, 1, 4'b0000);
        step(0, 1, 4'b0100);
        step(0, 0, 4'b0100);
        check("t4_busy_hold", 32'(busy_o[0]), 32'h1);
        step(0, 0, 4'b0100);
        check("t4_no_glitch", 32'(glitch_o[0]), 32'h0);
        step(0, 1, 4'b0100);
        check("t4_b_e4", 32'(b_o[0]), 32'h0);
        step(0, 1, 4'b0100);
        check("t4_b_e5", 32'(b_o[0]), 32'h4);
        check("t4_chg_e5", 32'(chg_o[0]), 32'h4);

        // Reset mid-qualification
        step(1, 1, 4'b0000);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0001);
        step(1, 1, 4'b0001);
        check("t5_busy_rst", 32'(busy_o[0]), 32'h0);
        check("t5_b_rst", 32'(b_o[0]), 32'h0);
        check("t5_glitch_rst", 32'(glitch_o[0]), 32'h0);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0001);
        check("t5_b_e2", 32'(b_o[0]), 32'h0);
        step(0, 1, 4'b0001);
        check("t5_b_e3", 32'(b_o[0]), 32'h1);

        // HOLD 1 follows a toggling input with one edge of latency
        step(1, 1, 4'b0000);
        for (int n = 0; n < 8; n++) begin
            step(0, 1, (n % 2 == 0) ? 4'b0101 : 4'b1010);
            check("t6_follow", 32'(b_o[2]), (n % 2 == 0) ? 32'h5 : 32'ha);
            check("t6_chg", 32'(chg_o[2]), (n == 0) ? 32'h5 : 32'hf);
        end

        // Mixed pattern with enable gaps, model-checked only
        step(0, 1, 4'b1100);
        step(0, 0, 4'b0011);
        step(0, 1, 4'b0110);
        step(0, 1, 4'b0110);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0010);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
